// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the word-indexed PC, drives the ROM
// address, loads the IF/ID register and sequences start, stall, redirect,
// early jump resolution and halt at the end of the program. It also keeps
// saturating fetch and flush counters.
module fetch_sequencer #(
  parameter int          DEPTH   = 32,
  parameter int          CNT_W   = 16,
  parameter logic [5:0]  JUMP_OP = 6'b000010
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_target,
  input  logic [31:0]      rom_instr,
  output logic [31:0]      rom_addr,
  output logic [31:0]      if_id_instr,
  output logic [31:0]      if_id_pc,
  output logic             if_id_valid,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [31:0]      DEPTH_W = 32'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       state_reg, state_next;
  logic [31:0]      pc_reg, pc_next;
  logic [31:0]      instr_reg, instr_next;
  logic [31:0]      ipc_reg, ipc_next;
  logic             valid_reg, valid_next;
  logic [CNT_W-1:0] fetch_cnt_reg, fetch_cnt_next;
  logic [CNT_W-1:0] flush_cnt_reg, flush_cnt_next;

  // Decoded properties of the word currently returned by the ROM.
  logic        is_jump;
  logic [31:0] jump_target;
  logic        pc_out_of_range;

  assign is_jump         = (rom_instr[31:26] == JUMP_OP);
  assign jump_target     = {6'b0, rom_instr[25:0]};
  assign pc_out_of_range = (pc_reg >= DEPTH_W);

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Next-state logic: redirect > stall > end of program > jump > sequential.
  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    instr_next     = instr_reg;
    ipc_next       = ipc_reg;
    valid_next     = valid_reg;
    fetch_cnt_next = fetch_cnt_reg;
    flush_cnt_next = flush_cnt_reg;

    case (state_reg)
      ST_IDLE: begin
        // IF/ID holds a bubble; only start is observed. PC is already 0.
        instr_next = 32'h0;
        ipc_next   = 32'h0;
        valid_next = 1'b0;
        if (start) begin
          state_next = ST_RUN;
        end
      end

      ST_RUN: begin
        if (redirect_valid) begin
          // The single slot in IF/ID is the wrong-path instruction; kill it.
          pc_next    = redirect_target;
          instr_next = 32'h0;
          ipc_next   = 32'h0;
          valid_next = 1'b0;
          if (valid_reg) begin
            flush_cnt_next = sat_inc(flush_cnt_reg);
          end
        end else if (stall) begin
          // Hold everything.
        end else if (pc_out_of_range) begin
          // Past the last ROM word: stop without consuming the ROM output.
          state_next = ST_DONE;
          instr_next = 32'h0;
          ipc_next   = 32'h0;
          valid_next = 1'b0;
        end else begin
          instr_next     = rom_instr;
          ipc_next       = pc_reg;
          valid_next     = 1'b1;
          fetch_cnt_next = sat_inc(fetch_cnt_reg);
          // Jumps resolve here so the following fetch is already on-path.
          pc_next        = is_jump ? jump_target : pc_reg + 32'd1;
        end
      end

      ST_DONE: begin
        // IF/ID is already invalid, so a redirect here flushes nothing.
        instr_next = 32'h0;
        ipc_next   = 32'h0;
        valid_next = 1'b0;
        if (redirect_valid) begin
          pc_next    = redirect_target;
          state_next = ST_RUN;
        end
      end

      default: begin
        // Unreachable encoding: fall back to a clean idle.
        state_next = ST_IDLE;
        pc_next    = 32'h0;
        instr_next = 32'h0;
        ipc_next   = 32'h0;
        valid_next = 1'b0;
      end
    endcase
  end

  // State and pipeline registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      pc_reg        <= 32'h0;
      instr_reg     <= 32'h0;
      ipc_reg       <= 32'h0;
      valid_reg     <= 1'b0;
      fetch_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      instr_reg     <= instr_next;
      ipc_reg       <= ipc_next;
      valid_reg     <= valid_next;
      fetch_cnt_reg <= fetch_cnt_next;
      flush_cnt_reg <= flush_cnt_next;
    end
  end

  assign rom_addr    = pc_reg;
  assign if_id_instr = instr_reg;
  assign if_id_pc    = ipc_reg;
  assign if_id_valid = valid_reg;
  assign busy        = (state_reg == ST_RUN);
  assign halted      = (state_reg == ST_DONE);
  assign fetch_count = fetch_cnt_reg;
  assign flush_count = flush_cnt_reg;

endmodule
